// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if
// Groups the display word input and the scanned digit outputs of the
// seven-segment scan controller into one bundle.
//   master : display word source / display observer
//            (drives word_in, key_active; sees the scan outputs)
//   slave  : disp_scan_ctrl itself
// Signals:
//   word_in      32  display word, nibble i = glyph code of digit i (digit 0 rightmost)
//   key_active    1  high while any key is pressed
//   an_n          8  digit anodes, active low, at most one bit low
//   digit_code    4  glyph code of the currently enabled digit
//   frame_start   1  one-cycle pulse on the first output cycle of digit 0
//   holding       1  high while the last note is held after key release
interface disp_scan_ctrl_if;
  logic [31:0] word_in;
  logic        key_active;
  logic [7:0]  an_n;
  logic [3:0]  digit_code;
  logic        frame_start;
  logic        holding;

  modport master (
    output word_in,
    output key_active,
    input  an_n,
    input  digit_code,
    input  frame_start,
    input  holding
  );

  modport slave (
    input  word_in,
    input  key_active,
    output an_n,
    output digit_code,
    output frame_start,
    output holding
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// The display word is latched into a shadow register only at frame
// boundaries (tick==0, idx==0), so a frame never mixes two words. After key
// release the last word is held for HOLD_FRAMES frames, then IDLE_WORD is
// shown. All outputs are registered, one cycle behind the counter state.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   bus   slave modport of disp_scan_ctrl_if
//         (word_in, key_active in; an_n, digit_code, frame_start, holding out)
//
// Optional feature macro: DISP_GUARD_EN
//   When defined, the anodes are blanked (an_n=8'hFF) during the first
//   GUARD_TICKS cycles of every digit slot to suppress ghosting. digit_code
//   and frame_start are unaffected. When undefined, GUARD_TICKS is ignored.
module disp_scan_ctrl #(
  parameter int          DIGIT_TICKS = 100000,
  parameter int          HOLD_FRAMES = 250,
  parameter int          GUARD_TICKS = 1000,
  parameter logic [31:0] IDLE_WORD   = 32'h0E5C_9999
) (
  input  logic            clk,
  input  logic            rst,
  disp_scan_ctrl_if.slave bus
);

  localparam int TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] GUARD_LIM = TW'(GUARD_TICKS);
  localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

`ifdef DISP_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  // scan counters
  logic [TW-1:0] tick_r;
  logic [2:0]    idx_r;
  logic [TW-1:0] tick_nxt_s;
  logic [2:0]    idx_nxt_s;

  // latched word and hold tracking
  logic [31:0]   shadow_r;
  logic [HW-1:0] hold_cnt_r;
  logic          holding_r;
  logic [31:0]   shadow_nxt_s;
  logic [HW-1:0] hold_cnt_nxt_s;
  logic          holding_nxt_s;

  // output registers
  logic [7:0]    an_n_r;
  logic [3:0]    digit_code_r;
  logic          frame_start_r;
  logic [7:0]    an_n_nxt_s;
  logic [3:0]    digit_code_nxt_s;

  logic          load_s;

  assign load_s = (tick_r == TICK_ZERO) && (idx_r == 3'd0);

  // Tick and digit-index advance; idx wraps 7 -> 0 naturally in 3 bits.
  always_comb begin
    tick_nxt_s = tick_r;
    idx_nxt_s  = idx_r;
    if (tick_r == TICK_LAST) begin
      tick_nxt_s = TICK_ZERO;
      idx_nxt_s  = idx_r + 3'd1;
    end else begin
      tick_nxt_s = tick_r + TICK_ONE;
      idx_nxt_s  = idx_r;
    end
  end

  // Frame-boundary load: new key word, hold countdown, or fall back to idle.
  always_comb begin
    shadow_nxt_s   = shadow_r;
    hold_cnt_nxt_s = hold_cnt_r;
    holding_nxt_s  = holding_r;
    if (load_s) begin
      if (bus.key_active) begin
        shadow_nxt_s   = bus.word_in;
        hold_cnt_nxt_s = HOLD_LOAD;
        holding_nxt_s  = 1'b0;
      end else if (hold_cnt_r != HOLD_ZERO) begin
        shadow_nxt_s   = shadow_r;
        hold_cnt_nxt_s = hold_cnt_r - HOLD_ONE;
        holding_nxt_s  = 1'b1;
      end else begin
        shadow_nxt_s   = IDLE_WORD;
        hold_cnt_nxt_s = HOLD_ZERO;
        holding_nxt_s  = 1'b0;
      end
    end else begin
      shadow_nxt_s   = shadow_r;
      hold_cnt_nxt_s = hold_cnt_r;
      holding_nxt_s  = holding_r;
    end
  end

  // Next output values. The nibble comes from the post-load shadow so the
  // first output cycle of a frame already shows the freshly latched word.
  always_comb begin
    an_n_nxt_s       = 8'hFF;
    digit_code_nxt_s = 4'h0;
    case (idx_r)
      3'd0:    digit_code_nxt_s = shadow_nxt_s[3:0];
      3'd1:    digit_code_nxt_s = shadow_nxt_s[7:4];
      3'd2:    digit_code_nxt_s = shadow_nxt_s[11:8];
      3'd3:    digit_code_nxt_s = shadow_nxt_s[15:12];
      3'd4:    digit_code_nxt_s = shadow_nxt_s[19:16];
      3'd5:    digit_code_nxt_s = shadow_nxt_s[23:20];
      3'd6:    digit_code_nxt_s = shadow_nxt_s[27:24];
      3'd7:    digit_code_nxt_s = shadow_nxt_s[31:28];
      default: digit_code_nxt_s = 4'h0;
    endcase
    if (GUARD_ON && (tick_r < GUARD_LIM)) begin
      an_n_nxt_s = 8'hFF;
    end else begin
      an_n_nxt_s = ~(8'h01 << idx_r);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r        <= TICK_ZERO;
      idx_r         <= 3'd0;
      shadow_r      <= IDLE_WORD;
      hold_cnt_r    <= HOLD_ZERO;
      holding_r     <= 1'b0;
      an_n_r        <= 8'hFF;
      digit_code_r  <= 4'h0;
      frame_start_r <= 1'b0;
    end else begin
      tick_r        <= tick_nxt_s;
      idx_r         <= idx_nxt_s;
      shadow_r      <= shadow_nxt_s;
      hold_cnt_r    <= hold_cnt_nxt_s;
      holding_r     <= holding_nxt_s;
      an_n_r        <= an_n_nxt_s;
      digit_code_r  <= digit_code_nxt_s;
      frame_start_r <= load_s;
    end
  end

  assign bus.an_n        = an_n_r;
  assign bus.digit_code  = digit_code_r;
  assign bus.frame_start = frame_start_r;
  assign bus.holding     = holding_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
// Self-checking bench for disp_scan_ctrl with DIGIT_TICKS=4, HOLD_FRAMES=2,
// GUARD_TICKS=1. Expected per-cycle outputs for each frame are pushed into a
// scoreboard queue and popped as the DUT produces each output cycle.
// Honors DISP_GUARD_EN the same way the design does.
module tb_disp_scan_ctrl;

  localparam int          DT   = 4;
  localparam int          HF   = 2;
  localparam int          GT   = 1;
  localparam logic [31:0] IDLE = 32'h0E5C_9999;
  localparam int          FRAME = 8 * DT;

`ifdef DISP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] code;
    logic       fs;
    logic       hold;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(
    .DIGIT_TICKS (DT),
    .HOLD_FRAMES (HF),
    .GUARD_TICKS (GT),
    .IDLE_WORD   (IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for output cycle c (0..31) of a frame showing word w.
  function automatic exp_t exp_for(input logic [31:0] w, input logic h, input int c);
    exp_t       e;
    int         d;
    int         t;
    logic [7:0] one8;
    one8   = 8'h01;
    d      = c / DT;
    t      = c % DT;
    e.an   = (GUARD && t < GT) ? 8'hFF : ~(one8 << d);
    e.code = w[4*d +: 4];
    e.fs   = (c == 0);
    e.hold = h;
    return e;
  endfunction

  // Run output cycles [first, last) of a frame; optionally change the
  // inputs right after output cycle chg_at has been observed.
  task automatic run_frame(input string name, input logic [31:0] w, input logic h,
                           input int first, input int last,
                           input int chg_at, input logic chg_key, input logic [31:0] chg_word);
    exp_t e;
    for (int c = first; c < last; c++) sb_q.push_back(exp_for(w, h, c));
    for (int c = first; c < last; c++) begin
      step();
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s cycle %0d: scoreboard empty, no expected value", name, c);
      end else begin
        e = sb_q.pop_front();
        if (bus.an_n !== e.an || bus.digit_code !== e.code ||
            bus.frame_start !== e.fs || bus.holding !== e.hold) begin
          errors++;
          $display("FAIL %s cycle %0d: got an_n=%h code=%h fs=%b hold=%b, expected an_n=%h code=%h fs=%b hold=%b",
                   name, c, bus.an_n, bus.digit_code, bus.frame_start, bus.holding,
                   e.an, e.code, e.fs, e.hold);
        end
      end
      if (c == chg_at) begin
        bus.key_active = chg_key;
        bus.word_in    = chg_word;
      end
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.key_active = 1'b0;
    bus.word_in    = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.an_n !== 8'hFF || bus.digit_code !== 4'h0 ||
          bus.frame_start !== 1'b0 || bus.holding !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc %0d: got an_n=%h code=%h fs=%b hold=%b, expected an_n=ff code=0 fs=0 hold=0",
                 i, bus.an_n, bus.digit_code, bus.frame_start, bus.holding);
      end
    end
    rst = 1'b0;
    run_frame("idle_f0", IDLE, 1'b0, 0, FRAME, -1, 1'b0, 32'h0);
    run_frame("idle_f1", IDLE, 1'b0, 0, FRAME, -1, 1'b0, 32'h0);
  endtask

  task automatic test_key_hold();
    bus.key_active = 1'b1;
    bus.word_in    = 32'h3E5C_D009;
    // Word changes mid-frame; the visible frame must not change.
    run_frame("key_frame", 32'h3E5C_D009, 1'b0, 0, FRAME, 10, 1'b1, 32'h1234_5678);
    bus.key_active = 1'b0;
    run_frame("hold_f1", 32'h3E5C_D009, 1'b1, 0, FRAME, -1, 1'b0, 32'h1234_5678);
    run_frame("hold_f2", 32'h3E5C_D009, 1'b1, 0, FRAME, -1, 1'b0, 32'h1234_5678);
    run_frame("hold_expired", IDLE, 1'b0, 0, FRAME, -1, 1'b0, 32'h1234_5678);
  endtask

  task automatic test_repress();
    bus.key_active = 1'b1;
    bus.word_in    = 32'h3E5C_D009;
    run_frame("rp_key", 32'h3E5C_D009, 1'b0, 0, FRAME, 2, 1'b0, 32'h3E5C_D009);
    run_frame("rp_hold1", 32'h3E5C_D009, 1'b1, 0, FRAME, -1, 1'b0, 32'h0);
    // Re-press during the second hold frame.
    run_frame("rp_hold2", 32'h3E5C_D009, 1'b1, 0, FRAME, 5, 1'b1, 32'h2E5C_96EB);
    run_frame("rp_new", 32'h2E5C_96EB, 1'b0, 0, FRAME, 3, 1'b0, 32'h2E5C_96EB);
    run_frame("rp_rehold1", 32'h2E5C_96EB, 1'b1, 0, FRAME, -1, 1'b0, 32'h0);
    run_frame("rp_rehold2", 32'h2E5C_96EB, 1'b1, 0, FRAME, -1, 1'b0, 32'h0);
    run_frame("rp_idle", IDLE, 1'b0, 0, FRAME, -1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_an;
    bus.key_active = 1'b1;
    bus.word_in    = 32'hA1B2_C3D4;
    run_frame("rm_key", 32'hA1B2_C3D4, 1'b0, 0, FRAME, 2, 1'b0, 32'hA1B2_C3D4);
    // Partial held frame up to the first output cycle of digit 5.
    run_frame("rm_hold", 32'hA1B2_C3D4, 1'b1, 0, 5 * DT + 1, -1, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.an_n !== 8'hFF || bus.frame_start !== 1'b0 || bus.holding !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_blank: got an_n=%h fs=%b hold=%b, expected an_n=ff fs=0 hold=0",
               bus.an_n, bus.frame_start, bus.holding);
    end
    step();
    exp_an = GUARD ? 8'hFF : 8'hFE;
    checks++;
    if (bus.frame_start !== 1'b1 || bus.an_n !== exp_an ||
        bus.digit_code !== 4'h9 || bus.holding !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_restart: got fs=%b an_n=%h code=%h hold=%b, expected fs=1 an_n=%h code=9 hold=0",
               bus.frame_start, bus.an_n, bus.digit_code, bus.holding, exp_an);
    end
    run_frame("rm_restart", IDLE, 1'b0, 1, FRAME, -1, 1'b0, 32'h0);
    run_frame("rm_after", IDLE, 1'b0, 0, FRAME, -1, 1'b0, 32'h0);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    rst            = 1'b1;
    bus.key_active = 1'b0;
    bus.word_in    = 32'h0000_0000;
    test_reset();
    test_key_hold();
    test_repress();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
